// File: rtl/sample_frame_aligner.sv
// sample_frame_aligner: collects one sample per enabled channel into per-lane
// slots and emits them as a single aligned frame. Sticky lanes may reuse
// their last emitted sample. A frame that never completes is forced out after
// TIMEOUT cycles, with its missing lanes flagged stale.
module sample_frame_aligner #(
  parameter int N_CH    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH-1:0]   ch_sticky,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  output logic [N_CH*W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_CH-1:0]   out_stale,
  output logic              out_timeout,
  output logic [N_CH-1:0]   ovr_flag,
  input  logic              ovr_clr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [N_CH-1:0][W-1:0] slot_q, slot_d;
  logic [N_CH-1:0][W-1:0] held_q, held_d;
  logic [N_CH-1:0]        full_q, full_d;
  logic [N_CH-1:0]        have_q, have_d;
  logic [N_CH*W-1:0]      out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic [N_CH-1:0]        out_stale_q, out_stale_d;
  logic                   out_timeout_q, out_timeout_d;
  logic [N_CH-1:0]        ovr_q, ovr_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [N_CH-1:0] ready;
  logic [N_CH-1:0] required;
  logic [N_CH-1:0] en_full;
  logic            complete;
  logic            timeout_hit;
  logic            load;

  // Frame decision: which lanes must be fresh, and whether a frame loads this edge.
  // A forced frame still needs one fresh enabled lane, so held-only frames never go out.
  always_comb begin
    ready       = ~full_q | ~ch_en;
    required    = ch_en & ~(ch_sticky & have_q);
    en_full     = ch_en & full_q;
    complete    = (&(~required | full_q)) & (|en_full);
    timeout_hit = (cnt_q == CNT_LAST) & (|en_full);
    load        = (complete | timeout_hit) & (~out_valid_q | out_ready);
  end

  // Per-lane slot capture, consumption on load, and held-sample history.
  always_comb begin
    slot_d = slot_q;
    held_d = held_q;
    full_d = full_q;
    have_d = have_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!ch_en[i]) begin
        full_d[i] = 1'b0;
      end else if (full_q[i]) begin
        if (load) begin
          full_d[i] = 1'b0;
          held_d[i] = slot_q[i];
          have_d[i] = 1'b1;
        end
      end else if (in_valid[i]) begin
        full_d[i] = 1'b1;
        slot_d[i] = in_data[i*W +: W];
      end
    end
  end

  // Output register: loads a frame, otherwise holds until accepted.
  always_comb begin
    out_data_d    = out_data_q;
    out_stale_d   = out_stale_q;
    out_timeout_d = out_timeout_q;
    out_valid_d   = out_valid_q & ~out_ready;
    if (load) begin
      out_valid_d   = 1'b1;
      out_timeout_d = ~complete;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (ch_en[i] && full_q[i]) begin
          out_data_d[i*W +: W] = slot_q[i];
          out_stale_d[i]       = 1'b0;
        end else if (ch_en[i]) begin
          out_data_d[i*W +: W] = have_q[i] ? held_q[i] : '0;
          out_stale_d[i]       = 1'b1;
        end else begin
          out_data_d[i*W +: W] = '0;
          out_stale_d[i]       = 1'b0;
        end
      end
    end
  end

  // Timeout counter saturates at its last value so a blocked forced frame waits for the output.
  always_comb begin
    cnt_d = cnt_q;
    if (load || !(|full_q)) begin
      cnt_d = '0;
    end else if ((|en_full) && !complete && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Sticky overflow flags; a set in the same cycle beats the clear.
  always_comb begin
    ovr_d = (in_valid & ~ready) | (ovr_q & ~{N_CH{ovr_clr}});
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q        <= '0;
      held_q        <= '0;
      full_q        <= '0;
      have_q        <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_stale_q   <= '0;
      out_timeout_q <= 1'b0;
      ovr_q         <= '0;
      cnt_q         <= '0;
    end else begin
      slot_q        <= slot_d;
      held_q        <= held_d;
      full_q        <= full_d;
      have_q        <= have_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_stale_q   <= out_stale_d;
      out_timeout_q <= out_timeout_d;
      ovr_q         <= ovr_d;
      cnt_q         <= cnt_d;
    end
  end

  assign in_ready    = ready;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_stale   = out_stale_q;
  assign out_timeout = out_timeout_q;
  assign ovr_flag    = ovr_q;

endmodule
